// File: rtl/alu_arbiter_pkg.sv
// ALU op codes and arbiter FSM encodings, shared between the arbiter and the ALU it fronts.
package alu_arbiter_pkg;

    localparam int ALU_OP_W = 3;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'b100;
    localparam logic [ALU_OP_W-1:0] ALU_NOR = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic is_unsupported(input logic [ALU_OP_W-1:0] op);
        return op >= 3'b110;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, shared-ALU and response signals around the arbiter.
interface alu_arbiter_if
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DATA_W  = 32
) ();

    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ*DATA_W-1:0]   req_a;
    logic [NUM_REQ*DATA_W-1:0]   req_b;
    logic [NUM_REQ*ALU_OP_W-1:0] req_op;

    logic [DATA_W-1:0]   alu_a;
    logic [DATA_W-1:0]   alu_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic [DATA_W-1:0]   alu_result;
    logic                alu_zero;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;
    logic              rsp_err;
    logic              busy;

    modport slave (
        input  req_valid, req_a, req_b, req_op, alu_result, alu_zero, rsp_ready,
        output req_ready, alu_a, alu_b, alu_op,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_op, alu_result, alu_zero, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_op,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, busy
    );

endinterface

// File: rtl/alu_arbiter_rr_picker.sv
// Round-robin pick: first set request at or above ptr, wrapping; purely combinational.
module alu_arbiter_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                idx      = ID_W'(j);
                grant[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one combinational ALU: grant in IDLE, one EXEC cycle, hold response in RESP.
// Accept at cycle T gives rsp_valid at T+2; rsp_ready low stalls in RESP with no new grants.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DATA_W  = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);

    state_e state, state_nxt;

    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;
    logic                grant_any;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     cur_id;
    logic [DATA_W-1:0]   alu_a_q, alu_b_q, rsp_result_q;
    logic [ALU_OP_W-1:0] alu_op_q;
    logic                rsp_zero_q, rsp_err_q, op_bad;

    alu_arbiter_rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_picker (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.req_ready = '0;
        bus.rsp_valid = 1'b0;
        bus.busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                bus.req_ready = grant;
                if (grant_any) state_nxt = ST_EXEC;
            end
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign op_bad = is_unsupported(alu_op_q);

    // ALU operand registers keep the last issued op so the shared ALU inputs never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            cur_id       <= '0;
            rr_ptr       <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        alu_a_q  <= bus.req_a[int'(grant_idx)*DATA_W +: DATA_W];
                        alu_b_q  <= bus.req_b[int'(grant_idx)*DATA_W +: DATA_W];
                        alu_op_q <= bus.req_op[int'(grant_idx)*ALU_OP_W +: ALU_OP_W];
                        cur_id   <= grant_idx;
                    end
                end
                ST_EXEC: begin
                    rsp_err_q    <= op_bad;
                    rsp_result_q <= op_bad ? '0   : bus.alu_result;
                    rsp_zero_q   <= op_bad ? 1'b1 : bus.alu_zero;
                    rr_ptr       <= (cur_id == ID_W'(NUM_REQ - 1)) ? '0 : cur_id + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.rsp_id     = cur_id;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a response scoreboard and a behavioural shared ALU.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int DATA_W  = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .DATA_W(DATA_W)) bus ();

    alu_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Shared ALU; unsupported codes return junk so the arbiter's forcing is visible.
    always_comb begin
        case (bus.alu_op)
            ALU_ADD: bus.alu_result = bus.alu_a + bus.alu_b;
            ALU_SUB: bus.alu_result = bus.alu_a - bus.alu_b;
            ALU_AND: bus.alu_result = bus.alu_a & bus.alu_b;
            ALU_OR:  bus.alu_result = bus.alu_a | bus.alu_b;
            ALU_XOR: bus.alu_result = bus.alu_a ^ bus.alu_b;
            ALU_NOR: bus.alu_result = ~(bus.alu_a | bus.alu_b);
            default: bus.alu_result = bus.alu_a ^ bus.alu_b ^ 32'h1234_5678;
        endcase
        bus.alu_zero = (bus.alu_result == '0);
    end

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        zero;
        logic        err;
        int          gcyc;
    } exp_t;

    exp_t exp_q[$];
    int   gq[$];
    int   gcyc_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    bit   one_shot   = 1'b1;
    bit   prev_rv    = 1'b0;
    bit   prev_stall = 1'b0;
    logic [NUM_REQ-1:0] gmask;
    logic [ID_W-1:0]    sv_id;
    logic [31:0]        sv_res;
    logic               sv_zero, sv_err;
    int                 last_id;
    logic [31:0]        last_res;
    logic               last_zero, last_err;

    function automatic exp_t model(input int id, input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] op, input int c);
        exp_t        e;
        logic [31:0] r;
        case (op)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            3'd5:    r = ~(a | b);
            default: r = '0;
        endcase
        e.id   = id;
        e.gcyc = c;
        e.err  = (op == 3'd6) || (op == 3'd7);
        e.res  = e.err ? 32'h0 : r;
        e.zero = e.err ? 1'b1 : (r == 32'h0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic observe();
        exp_t e;
        cyc++;
        gmask = bus.req_ready;
        if (bus.req_ready != '0) begin
            chk("grant_onehot", 64'($onehot(bus.req_ready)), 1);
            chk("grant_busy", bus.busy, 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_ready[i]) begin
                    chk("grant_valid", bus.req_valid[i], 1);
                    exp_q.push_back(model(i, bus.req_a[i*DATA_W +: DATA_W], bus.req_b[i*DATA_W +: DATA_W],
                                          bus.req_op[i*3 +: 3], cyc));
                    gq.push_back(i);
                    gcyc_q.push_back(cyc);
                end
            end
        end
        if (bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", bus.rsp_valid, 0);
            end else begin
                e = exp_q[0];
                if (!prev_rv) chk("rsp_latency", 64'(cyc - e.gcyc), 2);
                if (prev_stall) begin
                    chk("stall_id", bus.rsp_id, sv_id);
                    chk("stall_res", bus.rsp_result, sv_res);
                    chk("stall_zero", bus.rsp_zero, sv_zero);
                    chk("stall_err", bus.rsp_err, sv_err);
                end
                chk("resp_no_grant", bus.req_ready, 0);
                if (bus.rsp_ready) begin
                    void'(exp_q.pop_front());
                    chk("rsp_id", bus.rsp_id, 64'(e.id));
                    chk("rsp_result", bus.rsp_result, e.res);
                    chk("rsp_zero", bus.rsp_zero, e.zero);
                    chk("rsp_err", bus.rsp_err, e.err);
                    last_id   = int'(bus.rsp_id);
                    last_res  = bus.rsp_result;
                    last_zero = bus.rsp_zero;
                    last_err  = bus.rsp_err;
                end
            end
        end
        prev_stall = bus.rsp_valid && !bus.rsp_ready;
        prev_rv    = bus.rsp_valid;
        sv_id      = bus.rsp_id;
        sv_res     = bus.rsp_result;
        sv_zero    = bus.rsp_zero;
        sv_err     = bus.rsp_err;
    endtask

    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        if (one_shot) bus.req_valid = bus.req_valid & ~gmask;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || bus.busy || bus.req_valid != '0) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk("drain_timeout", 64'(n), 64'(budget - 1));
    endtask

    task automatic send(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        bus.req_a[i*DATA_W +: DATA_W] = a;
        bus.req_b[i*DATA_W +: DATA_W] = b;
        bus.req_op[i*3 +: 3]          = op;
        bus.req_valid[i]              = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, bus.req_ready, 0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_alu_a"}, bus.alu_a, 0);
        chk({tag, "_alu_b"}, bus.alu_b, 0);
        chk({tag, "_alu_op"}, bus.alu_op, 0);
        chk({tag, "_rsp_id"}, bus.rsp_id, 0);
        chk({tag, "_rsp_result"}, bus.rsp_result, 0);
        chk({tag, "_rsp_zero"}, bus.rsp_zero, 0);
        chk({tag, "_rsp_err"}, bus.rsp_err, 0);
    endtask

    initial begin
        int n;
        int exp_ord[6] = '{0, 1, 2, 3, 0, 1};
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b1;
        #2;
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All four requesters held valid: strict rotation, one grant every 3 cycles.
        one_shot = 1'b0;
        send(0, 32'd1, 32'd2, ALU_ADD);
        send(1, 32'd5, 32'd7, ALU_SUB);
        send(2, 32'hF0F0_1234, 32'h0FF0_FFFF, ALU_AND);
        send(3, 32'hAAAA_5555, 32'hAAAA_5555, ALU_XOR);
        gq.delete();
        gcyc_q.delete();
        repeat (18) tick();
        bus.req_valid = '0;
        one_shot = 1'b1;
        drain(20);
        chk("fair_count", 64'(gq.size()), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < gq.size()) chk("fair_order", 64'(gq[k]), 64'(exp_ord[k]));
            if (k > 0 && k < gcyc_q.size()) chk("fair_spacing", 64'(gcyc_q[k] - gcyc_q[k-1]), 3);
        end

        send(0, 32'hA5A5_A5A5, 32'h5A5A_5A5A, ALU_ADD);
        drain(20);
        chk("add_id", 64'(last_id), 0);
        chk("add_res", last_res, 32'hFFFF_FFFF);
        chk("add_zero", last_zero, 0);
        chk("add_err", last_err, 0);

        send(2, 32'hA5A5_A5A5, 32'h5A5A_5A5A, ALU_SUB);
        drain(20);
        chk("sub_id", 64'(last_id), 2);
        chk("sub_res", last_res, 32'h4B4B_4B4B);

        send(2, 32'hA5A5_A5A5, 32'h5A5A_5A5A, ALU_AND);
        drain(20);
        chk("and_res", last_res, 32'h0);
        chk("and_zero", last_zero, 1);

        send(2, 32'hA5A5_A5A5, 32'h5A5A_5A5A, ALU_NOR);
        drain(20);
        chk("nor_res", last_res, 32'h0);
        chk("nor_zero", last_zero, 1);

        // Backpressure with a competing requester waiting in IDLE.
        bus.rsp_ready = 1'b0;
        send(3, 32'h0F0F_0F0F, 32'hFFFF_0000, ALU_XOR);
        n = 0;
        while (!bus.rsp_valid && n < 10) begin
            tick();
            n++;
        end
        if (n >= 10) chk("bp_reach_timeout", 64'(n), 9);
        send(0, 32'd3, 32'd3, ALU_SUB);
        repeat (5) tick();
        chk("bp_held_valid", bus.rsp_valid, 1);
        bus.rsp_ready = 1'b1;
        tick();
        chk("bp_idle", bus.busy, 0);
        chk("xor_id", 64'(last_id), 3);
        chk("xor_res", last_res, 32'hF0F0_0F0F);
        drain(20);
        chk("bp_next_id", 64'(last_id), 0);
        chk("bp_next_zero", last_zero, 1);

        send(1, 32'd1, 32'd1, 3'b110);
        drain(20);
        chk("unsup_id", 64'(last_id), 1);
        chk("unsup_res", last_res, 32'h0);
        chk("unsup_zero", last_zero, 1);
        chk("unsup_err", last_err, 1);

        // Reset during EXEC drops the op and resets the round-robin pointer.
        send(1, 32'd7, 32'd8, ALU_OR);
        tick();
        chk("pre_rst_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        exp_q.delete();
        prev_rv    = 1'b0;
        prev_stall = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) tick();
        gq.delete();
        gcyc_q.delete();
        send(0, 32'd10, 32'd20, ALU_ADD);
        send(1, 32'd30, 32'd30, ALU_SUB);
        send(2, 32'hFF00_FF00, 32'h00FF_00FF, ALU_OR);
        send(3, 32'h0, 32'h0, ALU_NOR);
        drain(40);
        chk("post_rst_count", 64'(gq.size()), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < gq.size()) chk("post_rst_order", 64'(gq[k]), 64'(k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one combinational ALU (ops add/sub/and/or/xor/nor, 32-bit, zero flag) among NUM_REQ requesters. Round-robin arbitration, valid/ready on both sides. Drives the shared ALU's operand/op inputs from registers, samples result/zero, and returns a tagged registered response. Sits between datapath clients (e.g. branch unit, address generator, main execute) and the single ALU instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester index; must equal clog2(NUM_REQ)
DATA_W, 32, operand/result width; must match the ALU

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle
req_a  in  NUM_REQ*DATA_W  flattened operand A; requester i at [i*DATA_W +: DATA_W]
req_b  in  NUM_REQ*DATA_W  flattened operand B, same packing
req_op  in  NUM_REQ*3  flattened op codes, 3 bits per requester
alu_a  out  DATA_W  to shared ALU a
alu_b  out  DATA_W  to shared ALU b
alu_op  out  3  to shared ALU op
alu_result  in  DATA_W  from shared ALU result
alu_zero  in  1  from shared ALU zero
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  ID_W  index of requester served
rsp_result  out  DATA_W  registered ALU result
rsp_zero  out  1  registered zero flag
rsp_err  out  1  op code was 110 or 111 (unsupported)
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async on rst_n low, released synchronously by design): state=IDLE, rr_ptr=0, all outputs 0 (req_ready=0, alu_a/alu_b/alu_op=0, rsp_*=0, busy=0).
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any req_valid, pick first set bit scanning from rr_ptr upward with wrap; assert req_ready of that bit only (combinational on req_valid/state); on that edge latch a/b/op into alu_a/alu_b/alu_op, latch id, go EXEC. No valid -> stay IDLE, req_ready all 0.
- EXEC (exactly 1 cycle): ALU is combinational; at end of cycle capture alu_result->rsp_result, alu_zero->rsp_zero, rsp_err=(op>=3'b110); if rsp_err force rsp_result=0, rsp_zero=1. rr_ptr <= id+1 (mod NUM_REQ). Go RESP.
- RESP: rsp_valid=1; rsp_id/result/zero/err stable until handshake. rsp_valid & rsp_ready -> clear rsp_valid, go IDLE. rsp_ready low -> hold indefinitely.
- Latency: accept at edge T -> rsp_valid high from T+2. Max throughput one op per 3 cycles with rsp_ready tied high.
- req_ready never asserted outside IDLE; requesters hold req_* stable while valid and not accepted.
- alu_a/alu_b/alu_op hold last issued values after completion (no glitching to 0).
- Fairness: requester just served has lowest priority next arbitration; with all valid, grant order 0,1,2,3,0...
- Requester dropping req_valid before grant: no side effect.
- rst_n asserted mid EXEC/RESP: in-flight op discarded, no response emitted, state IDLE immediately.

Decomposition:
- Shared package/include alu_defs: op code constants ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_XOR=100, ALU_NOR=101; FSM state encodings; shared with the ALU.
- One sub-module: rr_picker (combinational: req vector + pointer -> one-hot grant + index). Rest lives in alu_arbiter.

Test Plan:
- Single req0: a=A5A5A5A5, b=5A5A5A5A, op=000 -> rsp_valid at T+2, rsp_id=0, rsp_result=FFFFFFFF, zero=0, err=0.
- Same operands op=001 from req2 -> result 4B4B4B4B, rsp_id=2; op=010 -> result 00000000, zero=1; op=101 -> 00000000, zero=1.
- All 4 requesters valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1; each grant one-hot; 3-cycle spacing.
- Backpressure: rsp_ready low 5 cycles in RESP -> rsp_valid and fields stable, no req_ready asserted; release -> IDLE next cycle.
- Unsupported op=110 from req1 -> rsp_err=1, rsp_result=0, rsp_zero=1, rsp_id=1.
- rst_n pulsed low during EXEC -> all outputs 0 immediately, no response; next request served by requester 0 first (rr_ptr=0).
